data_mem_resp: RTL and testbench

//  Responder (memory side) of the processor data-memory request/response interface.

---
 rtl/data_mem_resp.sv | 137 +++++++++++++
 tb/tb_data_mem_resp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Memory-side responder for the data-memory request/response interface.
// It accepts one load or store at a time, waits a fixed latency, then returns data and an error flag.
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wrt,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdat,
  input  logic [3:0]  req_be,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_dat,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  req_rdy_nxt, rsp_vld_nxt, rsp_err_nxt;
  logic [31:0]           rsp_dat_nxt;
  logic                  cap_wrt, cap_wrt_nxt;
  logic [31:0]           cap_addr, cap_addr_nxt;
  logic [31:0]           cap_wdat, cap_wdat_nxt;
  logic [3:0]            cap_be, cap_be_nxt;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acc_err;
  logic                  mem_we;

  assign idx     = cap_addr[DEPTH_LOG2+1:2];
  assign acc_err = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      cnt      <= 8'd0;
      req_rdy  <= 1'b0;
      rsp_vld  <= 1'b0;
      rsp_dat  <= 32'd0;
      rsp_err  <= 1'b0;
      cap_wrt  <= 1'b0;
      cap_addr <= 32'd0;
      cap_wdat <= 32'd0;
      cap_be   <= 4'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      req_rdy  <= req_rdy_nxt;
      rsp_vld  <= rsp_vld_nxt;
      rsp_dat  <= rsp_dat_nxt;
      rsp_err  <= rsp_err_nxt;
      cap_wrt  <= cap_wrt_nxt;
      cap_addr <= cap_addr_nxt;
      cap_wdat <= cap_wdat_nxt;
      cap_be   <= cap_be_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    req_rdy_nxt  = req_rdy;
    rsp_vld_nxt  = rsp_vld;
    rsp_dat_nxt  = rsp_dat;
    rsp_err_nxt  = rsp_err;
    cap_wrt_nxt  = cap_wrt;
    cap_addr_nxt = cap_addr;
    cap_wdat_nxt = cap_wdat;
    cap_be_nxt   = cap_be;
    mem_we       = 1'b0;

    case (state)
      INIT: begin
        state_nxt   = IDLE;
        req_rdy_nxt = 1'b1;
      end
      IDLE: begin
        if (req_vld && req_rdy) begin
          cap_wrt_nxt  = req_wrt;
          cap_addr_nxt = req_addr;
          cap_wdat_nxt = req_wdat;
          cap_be_nxt   = req_be;
          req_rdy_nxt  = 1'b0;
          cnt_nxt      = 8'(WAIT_CYC);
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          // The access happens on the edge that leaves WAIT, so a reset
          // asserted any time before this edge drops the request cleanly.
          rsp_vld_nxt = 1'b1;
          state_nxt   = RESP;
          if (acc_err) begin
            rsp_dat_nxt = 32'd0;
            rsp_err_nxt = 1'b1;
          end else if (cap_wrt) begin
            mem_we      = 1'b1;
            rsp_dat_nxt = 32'd0;
            rsp_err_nxt = 1'b0;
          end else begin
            rsp_dat_nxt = mem[idx];
            rsp_err_nxt = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_nxt = 1'b0;
          rsp_err_nxt = 1'b0;
          req_rdy_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[idx][8*i +: 8] <= cap_wdat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised scoreboard bench for data_mem_resp against a word-array reference model.
// A second instance with zero wait cycles covers the minimum-latency case.
module tb_data_mem_resp;

  localparam int WAIT_CYC   = 2;
  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_vld   = 1'b0;
  logic        req_wrt   = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdat  = 32'd0;
  logic [3:0]  req_be    = 4'd0;
  logic        rsp_rdy   = 1'b0;
  logic        req_rdy, rsp_vld, rsp_err;
  logic [31:0] rsp_dat;
  logic        req_vld0  = 1'b0;
  logic        req_rdy0, rsp_vld0, rsp_err0;
  logic [31:0] rsp_dat0;

  logic        rand_rdy  = 1'b0;
  logic        force_rdy = 1'b0;
  int          n_cmp     = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          accept_cyc = 0;
  logic [32:0] sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic        prev_vld  = 1'b0;
  logic        prev_rdy  = 1'b0;
  logic        prev_err  = 1'b0;
  logic [31:0] prev_dat  = 32'd0;

  data_mem_resp #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wrt(req_wrt),
    .req_addr(req_addr), .req_wdat(req_wdat), .req_be(req_be),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_err(rsp_err)
  );

  data_mem_resp #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld0), .req_rdy(req_rdy0), .req_wrt(req_wrt),
    .req_addr(req_addr), .req_wdat(req_wdat), .req_be(req_be),
    .rsp_vld(rsp_vld0), .rsp_rdy(1'b1), .rsp_dat(rsp_dat0), .rsp_err(rsp_err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response-ready changes 2 time units after the edge, well clear of the sampling edge.
  always @(posedge clk) begin
    #2;
    rsp_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory seen as whole words.
  function automatic logic [32:0] modelAccess(input logic wrt, input logic [31:0] addr,
                                              input logic [31:0] wdat, input logic [3:0] be);
    int w;
    if ((addr % 4) != 0 || addr >= 32'(4 * DEPTH)) return {1'b1, 32'd0};
    w = int'(addr / 4);
    if (wrt) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[w][8*b +: 8] = wdat[8*b +: 8];
      return {1'b0, 32'd0};
    end
    return {1'b0, model_mem[w]};
  endfunction

  task automatic waitReqRdy();
    int waited = 0;
    while (!req_rdy && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_rdy) checkOutput("req_rdy_timeout", 32'(req_rdy), 32'd1);
  endtask

  task automatic waitRspVld();
    int waited = 0;
    while (!rsp_vld && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rsp_vld) checkOutput("rsp_vld_timeout", 32'(rsp_vld), 32'd1);
  endtask

  task automatic applyStimulus(input logic wrt, input logic [31:0] addr,
                               input logic [31:0] wdat, input logic [3:0] be);
    waitReqRdy();
    if (!req_rdy) return;
    req_wrt  = wrt;
    req_addr = addr;
    req_wdat = wdat;
    req_be   = be;
    req_vld  = 1'b1;
    sb_q.push_back(modelAccess(wrt, addr, wdat, be));
    @(posedge clk); #1;
    accept_cyc = cyc;
    req_vld  = 1'b0;
    req_wrt  = 1'($urandom());
    req_addr = $urandom();
    req_wdat = $urandom();
    req_be   = 4'($urandom());
  endtask

  task automatic applyZeroWait(input logic wrt, input logic [31:0] addr,
                               input logic [31:0] wdat, input logic [31:0] exp);
    int waited = 0;
    while (!req_rdy0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("w0_req_rdy", 32'(req_rdy0), 32'd1);
    req_wrt  = wrt;
    req_addr = addr;
    req_wdat = wdat;
    req_be   = 4'hF;
    req_vld0 = 1'b1;
    @(posedge clk); #1;
    req_vld0 = 1'b0;
    checkOutput("w0_vld_at_accept", 32'(rsp_vld0), 32'd0);
    @(posedge clk); #1;
    checkOutput("w0_vld_next_edge", 32'(rsp_vld0), 32'd1);
    checkOutput("w0_dat", rsp_dat0, exp);
    checkOutput("w0_err", 32'(rsp_err0), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks protocol timing.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rdy_vld_excl", 32'(req_rdy & rsp_vld), 32'd0);
      if (rsp_vld && !prev_vld)
        checkOutput("latency", 32'(cyc - accept_cyc), 32'(WAIT_CYC + 1));
      if (rsp_vld && prev_vld && !prev_rdy) begin
        checkOutput("hold_dat", rsp_dat, prev_dat);
        checkOutput("hold_err", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_vld && rsp_rdy) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_vld), 32'd0);
        end else begin
          logic [32:0] exp;
          exp = sb_q.pop_front();
          checkOutput("rsp_dat", rsp_dat, exp[31:0]);
          checkOutput("rsp_err", 32'(rsp_err), 32'(exp[32]));
        end
      end
    end
    prev_vld = rsp_vld;
    prev_rdy = rsp_rdy;
    prev_dat = rsp_dat;
    prev_err = rsp_err;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          waited;

    #1;
    checkOutput("reset_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    checkOutput("reset_rsp_dat", rsp_dat, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("init_req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk); #1;
    checkOutput("release_req_rdy", 32'(req_rdy), 32'd1);
    force_rdy = 1'b1;

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i * 4), $urandom(), 4'hF);

    applyStimulus(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h10, 32'h5555_5555, 4'b0000);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);

    applyStimulus(1'b0, 32'h11, 32'h0, 4'hF);
    applyStimulus(1'b0, 32'h400, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h12, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);

    // Backpressure: response must hold while rsp_rdy stays low.
    waitReqRdy();
    force_rdy = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    waitRspVld();
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_req_rdy", 32'(req_rdy), 32'd0);
      checkOutput("bp_rsp_vld", 32'(rsp_vld), 32'd1);
    end
    force_rdy = 1'b1;
    @(posedge clk); #1;
    force_rdy = 1'b0;
    checkOutput("bp_release_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("bp_release_rsp_vld", 32'(rsp_vld), 32'd0);
    force_rdy = 1'b1;

    // Reset while a completed response is waiting for the initiator.
    waitReqRdy();
    force_rdy = 1'b0;
    applyStimulus(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF);
    waitRspVld();
    rst = 1'b0;
    #1;
    checkOutput("midrst_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
    checkOutput("midrst_rsp_err", 32'(rsp_err), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    checkOutput("midrst_hold_req_rdy", 32'(req_rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_release_req_rdy", 32'(req_rdy), 32'd1);
    force_rdy = 1'b1;
    applyStimulus(1'b0, 32'h30, 32'h0, 4'hF);

    // Reset between accept and access drops the store.
    waitReqRdy();
    req_wrt  = 1'b1;
    req_addr = 32'h20;
    req_wdat = 32'hFFFF_FFFF;
    req_be   = 4'hF;
    req_vld  = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("drop_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("drop_rsp_vld", 32'(rsp_vld), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("drop_release_req_rdy", 32'(req_rdy), 32'd1);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF);

    waitReqRdy();
    applyZeroWait(1'b1, 32'h8, 32'hCAFE_F00D, 32'h0);
    applyZeroWait(1'b0, 32'h8, 32'h0, 32'hCAFE_F00D);

    rand_rdy = 1'b1;
    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = $urandom() | 32'h400;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()));
    end

    waited = 0;
    while ((sb_q.size() != 0 || rsp_vld) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
